// File: rtl/pwm_duty_capture.sv
// Measures period and high time of an external PWM input, derives a 6-bit duty (0..63)
// with a 7-cycle restoring divider, and flags an input that stops producing rising edges.
module pwm_duty_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [5:0]       duty,
  output logic             duty_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;
  logic                   pwm_s;
  logic                   rise;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  state_t state_q, state_d;
  logic   capture;
  logic   timeout;

  logic             meas_valid_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             stuck_q;
  logic             stuck_level_q;

  logic             div_busy_q;
  logic [2:0]       div_step_q;
  logic [CNT_W:0]   div_rem_q;
  logic [CNT_W-1:0] div_den_q;
  logic [5:0]       div_quo_q;
  logic             div_ge;
  logic [CNT_W:0]   div_sub;
  logic [CNT_W-1:0] div_diff;
  logic [CNT_W:0]   div_rem_nxt;
  logic [5:0]       duty_q;
  logic             duty_valid_q;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q <= pwm_s;
    end
  end

  // Both counters include the rise cycle itself, so a P-cycle period reads back as P.
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      pcnt_d = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_W'(1);
      if (pwm_s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rise)    state_d = S_MEASURE;
      S_MEASURE: if (timeout) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Equality fires once per edgeless stretch since pcnt keeps climbing past the limit.
  always_comb begin
    timeout = ~rise && (pcnt_q == TIMEOUT);
    capture = (state_q == S_MEASURE) && rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid_q  <= 1'b0;
      period_q      <= '0;
      high_q        <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      meas_valid_q <= capture;
      if (capture) begin
        period_q <= pcnt_q;
        high_q   <= hcnt_q;
      end
      if (timeout) begin
        stuck_q       <= 1'b1;
        stuck_level_q <= pwm_s;
      end else if (rise) begin
        stuck_q <= 1'b0;
      end
    end
  end

  // One quotient bit per cycle: compare, subtract, then double the remainder for the next bit.
  always_comb begin
    div_ge      = (div_rem_q >= {1'b0, div_den_q});
    div_sub     = div_ge ? {1'b0, div_den_q} : '0;
    div_diff    = CNT_W'(div_rem_q - div_sub);
    div_rem_nxt = {div_diff, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_busy_q   <= 1'b0;
      div_step_q   <= '0;
      div_rem_q    <= '0;
      div_den_q    <= '0;
      div_quo_q    <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      if (capture) begin
        div_busy_q <= 1'b1;
        div_step_q <= '0;
        div_rem_q  <= {1'b0, hcnt_q};
        div_den_q  <= pcnt_q;
        div_quo_q  <= '0;
      end else if (div_busy_q) begin
        div_quo_q  <= {div_quo_q[4:0], div_ge};
        div_rem_q  <= div_rem_nxt;
        div_step_q <= div_step_q + 3'd1;
        if (div_step_q == 3'd6) begin
          div_busy_q   <= 1'b0;
          duty_valid_q <= 1'b1;
          duty_q       <= div_quo_q[5] ? 6'd63 : {div_quo_q[4:0], div_ge};
        end
      end
    end
  end

  assign meas_valid  = meas_valid_q;
  assign period_cnt  = period_q;
  assign high_cnt    = high_q;
  assign duty        = duty_q;
  assign duty_valid  = duty_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench: the PWM driver queues expected measurements and duties; a negedge monitor checks them.
module tb_pwm_duty_capture;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic        meas_valid;
  logic [15:0] period_cnt;
  logic [15:0] high_cnt;
  logic [5:0]  duty;
  logic        duty_valid;
  logic        stuck;
  logic        stuck_level;

  pwm_duty_capture #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(1023)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .meas_valid(meas_valid), .period_cnt(period_cnt), .high_cnt(high_cnt),
    .duty(duty), .duty_valid(duty_valid),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int p; int h; } meas_t;
  meas_t meas_q[$];
  int    duty_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    last_meas_cyc = 0;
  meas_t mon_m;
  int    mon_d;

  bit have_prev = 0;
  int prev_p, prev_h, prev_duty;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (duty_valid) begin
      if (duty_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected duty_valid: duty=%0d, expected no pulse (cycle %0d)", duty, cyc);
      end else begin
        mon_d = duty_q.pop_front();
        check("duty", int'(duty), mon_d);
        check("duty latency", cyc - last_meas_cyc, 7);
      end
    end
    if (meas_valid) begin
      if (meas_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected meas_valid: period=%0d high=%0d, expected no pulse (cycle %0d)",
                 period_cnt, high_cnt, cyc);
      end else begin
        mon_m = meas_q.pop_front();
        check("period_cnt", int'(period_cnt), mon_m.p);
        check("high_cnt", int'(high_cnt), mon_m.h);
      end
      last_meas_cyc = cyc;
    end
  end

  // The period that just ended is measured at this rise; its duty survives only if the
  // divider gets >= 8 cycles before the next capture (or no further rise follows).
  task automatic drive_period(input int p, input int h, input int exp_duty, input bit last);
    if (have_prev) begin
      meas_q.push_back('{prev_p, prev_h});
      if (p >= 8 || last) duty_q.push_back(prev_duty);
    end
    have_prev = 1;
    prev_p    = p;
    prev_h    = h;
    prev_duty = exp_duty;
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic idle(input int n);
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    have_prev = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " meas_valid"}, int'(meas_valid), 0);
    check({tag, " period_cnt"}, int'(period_cnt), 0);
    check({tag, " high_cnt"}, int'(high_cnt), 0);
    check({tag, " duty"}, int'(duty), 0);
    check({tag, " duty_valid"}, int'(duty_valid), 0);
    check({tag, " stuck"}, int'(stuck), 0);
    check({tag, " stuck_level"}, int'(stuck_level), 0);
  endtask

  initial begin
    bit seen;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Period 64, high 20 -> duty 20
    for (int i = 0; i < 4; i++) drive_period(64, 20, 20, i == 3);
    idle(20);

    // Period 100 with high 50 -> 32, then high 99 -> 63
    do_reset();
    for (int i = 0; i < 3; i++) drive_period(100, 50, 32, 1'b0);
    for (int i = 0; i < 3; i++) drive_period(100, 99, 63, i == 2);
    idle(20);

    // Short period 5/2 starves the divider; last one completes once period 64 begins (128/5 -> 25)
    do_reset();
    for (int i = 0; i < 8; i++) drive_period(5, 2, 25, 1'b0);
    for (int i = 0; i < 3; i++) drive_period(64, 20, 20, i == 2);
    idle(20);

    // Single-cycle pulse every 40 cycles -> 64/40 -> 1
    do_reset();
    for (int i = 0; i < 4; i++) drive_period(40, 1, 1, i == 3);
    idle(20);

    // Reset three cycles into the divide: no duty_valid afterwards, outputs cleared
    do_reset();
    drive_period(64, 20, 20, 1'b0);
    meas_q.push_back('{64, 20});
    have_prev = 0;
    pwm_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (meas_valid) seen = 1;
    end
    check("meas_valid before mid-divide reset", int'(seen), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-divide reset");
    rst = 1'b0;
    idle(20);

    // Input held high from reset -> stuck with level 1, cleared by the next rise
    pwm_in = 1'b1;
    do_reset();
    pwm_in = 1'b1;
    repeat (1020) @(negedge clk);
    check("stuck before timeout", int'(stuck), 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (stuck) seen = 1;
    end
    check("stuck after timeout", int'(seen), 1);
    check("stuck_level", int'(stuck_level), 1);
    idle(10);
    check("stuck held until rise", int'(stuck), 1);
    drive_period(64, 20, 20, 1'b0);
    check("stuck cleared by rise", int'(stuck), 0);
    for (int i = 0; i < 3; i++) drive_period(64, 20, 20, i == 2);
    idle(20);

    check("meas queue drained", meas_q.size(), 0);
    check("duty queue drained", duty_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
